// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_mem_pkg
// Brief    : Shared data-memory definitions: store size codes, byte-lane
//            enable constants and the store lane-formatting function.
// Revision : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Lane 3 (dm[31:24]) holds the byte at word offset 00: memory is
  // little-endian, so lanes run opposite to byte offsets.
  localparam logic [3:0] WE_WORD = 4'hF;
  localparam logic [3:0] WE_B0   = 4'h8;

  typedef struct packed {
    logic        misalign;
    logic [3:0]  we;
    logic [31:0] wdata;
  } st_fmt_t;

  // Replicates the store data across the lanes it may land in, so the lane
  // enables alone decide which bytes are written.
  function automatic st_fmt_t fmt_store(input logic [1:0]  size,
                                        input logic [1:0]  addr_lo,
                                        input logic [31:0] data);
    st_fmt_t f;
    f.misalign = 1'b0;
    f.we       = 4'b0000;
    f.wdata    = 32'h0;
    case (size)
      SZ_BYTE: begin
        f.we    = WE_B0 >> addr_lo;
        f.wdata = {4{data[7:0]}};
      end
      SZ_HALF: begin
        f.misalign = addr_lo[0];
        f.we       = addr_lo[1] ? 4'b0011 : 4'b1100;
        f.wdata    = {data[7:0], data[15:8], data[7:0], data[15:8]};
      end
      SZ_WORD: begin
        f.misalign = (addr_lo != 2'b00);
        f.we       = WE_WORD;
        f.wdata    = {data[7:0], data[15:8], data[23:16], data[31:24]};
      end
      default: begin
        f.misalign = 1'b1;
      end
    endcase
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with separate occupancy counter. Push when
//            full and pop when empty are ignored internally.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_push = i_push & ~w_full;
  assign w_do_pop  = i_pop & ~w_empty;

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Brief    : Buffers MEM-stage stores, formats them into data-memory lane
//            layout and drains them in order over a valid/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid_i,
  input  logic [1:0]                 st_size_i,
  input  logic [AW-1:0]              st_addr_i,
  input  logic [31:0]                st_data_i,
  output logic                       st_ready_o,
  output logic                       st_misalign_o,
  output logic                       dm_req_o,
  output logic [AW-1:0]              dm_addr_o,
  output logic [31:0]                dm_wdata_o,
  output logic [3:0]                 dm_we_o,
  input  logic                       dm_ack_i,
  output logic                       sb_empty_o,
  output logic [$clog2(DEPTH+1)-1:0] sb_count_o
);

  import mips_mem_pkg::*;

  localparam int EW = (AW - 2) + 4 + 32;

  logic          r_live;
  logic          r_misalign;
  st_fmt_t       w_fmt;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [EW-1:0] w_entry;
  logic [EW-1:0] w_head;
  logic [AW-3:0] w_head_waddr;
  logic [3:0]    w_head_we;
  logic [31:0]   w_head_wdata;

  assign w_fmt    = fmt_store(st_size_i, st_addr_i[1:0], st_data_i);
  assign w_accept = st_valid_i & st_ready_o;
  assign w_push   = w_accept & ~w_fmt.misalign;
  assign w_pop    = dm_ack_i & dm_req_o;
  assign w_entry  = {st_addr_i[AW-1:2], w_fmt.we, w_fmt.wdata};

  // Holds ready low during reset and releases it on the first edge after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_live <= 1'b0;
    else     r_live <= 1'b1;
  end

  // One-cycle pulse for a dropped (misaligned or reserved-size) store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_misalign <= 1'b0;
    else     r_misalign <= w_accept & w_fmt.misalign;
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (sb_count_o)
  );

  assign {w_head_waddr, w_head_we, w_head_wdata} = w_head;

  // Ready depends only on registered occupancy: no path from dm_ack_i.
  assign st_ready_o    = r_live & ~w_full;
  assign st_misalign_o = r_misalign;
  assign sb_empty_o    = w_empty;
  assign dm_req_o      = ~w_empty;
  assign dm_addr_o     = w_empty ? '0 : {w_head_waddr, 2'b00};
  assign dm_we_o       = w_empty ? 4'b0000 : w_head_we;
  assign dm_wdata_o    = w_empty ? 32'h0 : w_head_wdata;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Brief    : Directed self-checking bench for store_buffer (DEPTH=4, AW=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

  localparam logic [1:0] SZB = 2'b00;
  localparam logic [1:0] SZH = 2'b01;
  localparam logic [1:0] SZW = 2'b10;
  localparam logic [1:0] SZR = 2'b11;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        st_misalign;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_we;
  logic        dm_ack;
  logic        sb_empty;
  logic [2:0]  sb_count;

  int n_cmp;
  int n_err;

  store_buffer #(.DEPTH(4), .AW(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .st_valid_i    (st_valid),
    .st_size_i     (st_size),
    .st_addr_i     (st_addr),
    .st_data_i     (st_data),
    .st_ready_o    (st_ready),
    .st_misalign_o (st_misalign),
    .dm_req_o      (dm_req),
    .dm_addr_o     (dm_addr),
    .dm_wdata_o    (dm_wdata),
    .dm_we_o       (dm_we),
    .dm_ack_i      (dm_ack),
    .sb_empty_o    (sb_empty),
    .sb_count_o    (sb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_size  = sz;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req"},   dm_req,   0);
    check({tag, "_addr"},  dm_addr,  0);
    check({tag, "_we"},    dm_we,    0);
    check({tag, "_wdata"}, dm_wdata, 0);
    check({tag, "_empty"}, sb_empty, 1);
    check({tag, "_count"}, sb_count, 0);
  endtask

  initial begin
    int mc, nd, np, cyc, acc;
    logic exp_rdy;
    n_cmp = 0; n_err = 0;
    rst = 1'b1; st_valid = 1'b0; st_size = 2'b00; st_addr = '0; st_data = '0; dm_ack = 1'b0;

    // ---- reset values ----
    repeat (2) @(posedge clk);
    #1;
    check_idle("rst");
    check("rst_ready", st_ready, 0);
    check("rst_mis",   st_misalign, 0);
    rst = 1'b0;
    check("ready_before_edge", st_ready, 0);
    tick();
    check("ready_after_edge", st_ready, 1);

    // ---- T1: SW with ack held high ----
    dm_ack = 1'b1;
    drive(SZW, 32'h100, 32'h1122_3344);
    tick();
    st_valid = 1'b0;
    check("t1_req",   dm_req,   1);
    check("t1_addr",  dm_addr,  32'h100);
    check("t1_we",    dm_we,    4'hF);
    check("t1_wdata", dm_wdata, 32'h4433_2211);
    check("t1_count", sb_count, 1);
    tick();
    check_idle("t1_drained");
    dm_ack = 1'b0;

    // ---- T2: SB then SH, ack low ----
    drive(SZB, 32'h203, 32'h0000_00AB);
    tick();
    drive(SZH, 32'h202, 32'h0000_BEEF);
    tick();
    st_valid = 1'b0;
    check("t2_count2", sb_count, 2);
    check("t2_addr0",  dm_addr,  32'h200);
    check("t2_we0",    dm_we,    4'b0001);
    check("t2_wdata0", dm_wdata, 32'hABAB_ABAB);
    tick();
    check("t2_hold_we",    dm_we,    4'b0001);
    check("t2_hold_wdata", dm_wdata, 32'hABAB_ABAB);
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    check("t2_count1", sb_count, 1);
    check("t2_addr1",  dm_addr,  32'h200);
    check("t2_we1",    dm_we,    4'b0011);
    check("t2_wdata1", dm_wdata, 32'hEFBE_EFBE);
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    check("t2_empty", sb_empty, 1);

    // ---- T2b: SB lane 3 and SH lower half ----
    drive(SZB, 32'h300, 32'h1234_5677);
    tick();
    drive(SZH, 32'h304, 32'h0000_CAFE);
    tick();
    st_valid = 1'b0;
    check("t2b_we_b0",  dm_we,    4'b1000);
    check("t2b_wd_b0",  dm_wdata, 32'h7777_7777);
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    check("t2b_addr_h", dm_addr,  32'h304);
    check("t2b_we_h0",  dm_we,    4'b1100);
    check("t2b_wd_h0",  dm_wdata, 32'hFECA_FECA);
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;

    // ---- T3: misaligned / reserved stores are dropped ----
    drive(SZW, 32'h102, 32'hDEAD_BEEF);
    tick();
    st_valid = 1'b0;
    check("t3_mis_sw",   st_misalign, 1);
    check("t3_count_sw", sb_count, 0);
    check("t3_req_sw",   dm_req, 0);
    tick();
    check("t3_mis_clr1", st_misalign, 0);
    drive(SZH, 32'h101, 32'h0000_1234);
    tick();
    st_valid = 1'b0;
    check("t3_mis_sh",   st_misalign, 1);
    check("t3_count_sh", sb_count, 0);
    tick();
    check("t3_mis_clr2", st_misalign, 0);
    drive(SZR, 32'h300, 32'h0);
    tick();
    st_valid = 1'b0;
    check("t3_mis_rsv", st_misalign, 1);
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    check("t3_ack_ignored", sb_count, 0);
    check("t3_req_final",   dm_req, 0);

    // ---- T4: fill to DEPTH, fifth held off ----
    for (int k = 1; k <= 4; k++) begin
      drive(SZW, 32'h400 + 32'(4 * k), 32'(k));
      tick();
    end
    check("t4_ready_full", st_ready, 0);
    check("t4_count_full", sb_count, 4);
    drive(SZW, 32'h414, 32'd5);
    tick();
    check("t4_held_count", sb_count, 4);
    check("t4_head1",      dm_addr, 32'h404);
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    check("t4_ready_back", st_ready, 1);
    check("t4_count3",     sb_count, 3);
    tick();
    st_valid = 1'b0;
    check("t4_count4", sb_count, 4);
    dm_ack = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      check("t4_drain_addr",  dm_addr,  32'h400 + 32'(4 * k));
      check("t4_drain_wdata", dm_wdata, {8'(k), 24'h0});
      tick();
    end
    dm_ack = 1'b0;
    check("t4_empty", sb_empty, 1);

    // ---- T5: start full, ack held high, continuous valid ----
    for (int k = 1; k <= 4; k++) begin
      drive(SZW, 32'h800 + 32'(4 * k), 32'hA0 + 32'(k));
      tick();
    end
    st_valid = 1'b0;
    mc = 4; nd = 1; np = 5; cyc = 0;
    dm_ack = 1'b1;
    while (nd <= 8 && cyc < 40) begin
      if (np <= 8) drive(SZW, 32'h800 + 32'(4 * np), 32'hA0 + 32'(np));
      else         st_valid = 1'b0;
      exp_rdy = (mc != 4);
      check("t5_ready", st_ready, exp_rdy);
      if (mc > 0) begin
        check("t5_head_addr",  dm_addr,  32'h800 + 32'(4 * nd));
        check("t5_head_wdata", dm_wdata, {8'(32'hA0 + nd), 24'h0});
        nd++;
      end
      acc = (st_valid && exp_rdy) ? 1 : 0;
      if (acc == 1) np++;
      mc = mc + acc - ((mc > 0) ? 1 : 0);
      tick();
      cyc++;
    end
    st_valid = 1'b0;
    dm_ack = 1'b0;
    check("t5_all_drained", nd, 9);
    check("t5_empty", sb_empty, 1);

    // ---- T6: reset with entries pending ----
    for (int k = 1; k <= 3; k++) begin
      drive(SZW, 32'hC00 + 32'(4 * k), 32'h5500_0000 + 32'(k));
      tick();
    end
    st_valid = 1'b0;
    check("t6_count3", sb_count, 3);
    check("t6_req",    dm_req, 1);
    #2;
    rst = 1'b1;
    #1;
    check_idle("t6_in_rst");
    check("t6_ready_rst", st_ready, 0);
    dm_ack = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("t6_ready_after", st_ready, 1);
    for (int k = 0; k < 3; k++) begin
      check_idle("t6_post");
      tick();
    end
    dm_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-side counterpart of the writeback load-data path: the MEM stage issues stores (SB/SH/SW) to this block, which buffers them and drains them to data memory.
- Formats each store into the data-memory byte-lane layout the load path expects:
  - word bytes swapped (little-endian memory);
  - byte enable 4'b1000 selects dm[31:24].
- Drains buffered stores one at a time over a valid/ack handshake.
- Sits between the MEM stage and the data-memory port; tells the pipeline when it may issue loads, via sb_empty_o.

Parameters:
- DEPTH, 4: number of buffered stores; power of two, at least 2.
- AW, 32: address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- st_valid_i  in  1  MEM stage presents a store.
- st_size_i  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- st_addr_i  in  AW  byte address of the store.
- st_data_i  in  32  register rt value; the store uses the low bits.
- st_ready_o  out  1  buffer can accept; equals not full.
- st_misalign_o  out  1  one-cycle pulse: last accepted store was misaligned or reserved-size, and was dropped.
- dm_req_o  out  1  head entry valid toward data memory.
- dm_addr_o  out  AW  word address {addr[AW-1:2],2'b00} of the head entry.
- dm_wdata_o  out  32  lane-formatted write data of the head entry.
- dm_we_o  out  4  byte-lane write enables of the head entry.
- dm_ack_i  in  1  memory accepted the head entry this cycle.
- sb_empty_o  out  1  no store pending; the pipeline must stall loads while this is 0.
- sb_count_o  out  clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Reset (async on rst high):
  - pointers and count cleared; all entries discarded, including a store mid-handshake;
  - output values during reset: st_ready_o=0, st_misalign_o=0, dm_req_o=0, dm_addr_o=0, dm_wdata_o=0, dm_we_o=0, sb_empty_o=1, sb_count_o=0;
  - st_ready_o=1 from the first edge after rst falls.
- Accept: a store is accepted on st_valid_i & st_ready_o at an edge. If aligned, it is formatted and pushed.
- Formatting (b = st_data_i; lane3 = bits 31:24):
  - SB: we = 1000 >> addr[1:0]; wdata = {4{b[7:0]}}.
  - SH with addr[1]=0: we = 1100; wdata = {b[7:0], b[15:8], b[7:0], b[15:8]}.
  - SH with addr[1]=1: we = 0011; same wdata.
  - SW: we = 1111; wdata = {b[7:0], b[15:8], b[23:16], b[31:24]}.
- Misalignment: SH with addr[0]=1, SW with addr[1:0]!=0, or size 11.
  - Not pushed.
  - st_misalign_o pulses high for exactly one cycle, in the cycle after acceptance.
- Latency: a store accepted at edge N drives dm_req_o=1 no earlier than after edge N. No combinational path from st_* to dm_*.
- Drain:
  - dm_req_o = not empty; dm_* are driven from the head entry.
  - Payload stays stable while dm_req_o=1 and dm_ack_i=0.
  - dm_ack_i while dm_req_o=1 pops the head at that edge.
  - dm_ack_i while dm_req_o=0 is ignored.
  - While dm_req_o=0, dm_addr_o, dm_wdata_o and dm_we_o are 0.
- Ordering: strict FIFO; stores reach memory in acceptance order.
- Simultaneous push and pop when not full: both happen; count unchanged.
- Full: st_ready_o=0, even if a pop occurs in the same cycle. No push when full, so no combinational ready path from dm_ack_i.
- Empty with a push in the same edge: the entry appears after that edge; nothing bypasses.
- Pointers: log2(DEPTH) bits, wrap naturally; count derived from a separate counter.
- sb_empty_o = (count==0), registered-equivalent.

Decomposition:
- Shared package mips_mem_pkg:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - byte-enable constants WE_WORD=4'hF and WE_B0=4'h8 (lane3 for addr 00);
  - function fmt_store(size, addr[1:0], data) returning {misalign, we, wdata}.
- Sub-module sync_fifo (parameters WIDTH and DEPTH; push/pop/full/empty/count) holds entries of {word addr, we, wdata}.
- store_buffer itself handles formatting, misalign pulse, and handshake glue.

Test Plan:
- Reset then SW addr 0x100 data 0x11223344, dm_ack_i held 1 → next cycle dm_req_o=1, dm_addr_o=0x100, dm_we_o=1111, dm_wdata_o=0x44332211; popped at that edge; sb_empty_o returns to 1.
- SB at addr 0x203 data 0xAB, then SH at 0x202 data 0xBEEF, ack held 0 → head we=0001 wdata=0xABABABAB; after one ack, head we=0011 wdata=0xEFBEEFBE, addr 0x200; sb_count_o goes 2 then 1.
- SW at 0x102, then SH at 0x101 → st_misalign_o pulses once per store, one cycle after each acceptance; sb_count_o stays 0; dm_req_o stays 0.
- DEPTH=4, five back-to-back SW, ack low → st_ready_o falls after the 4th; 5th held off; one ack → st_ready_o=1 next cycle; then 5th accepted; memory order 1..5 preserved.
- Full buffer, ack held 1, continuous valid → ready held 0 in the pop cycle, so throughput alternates; no entry lost or duplicated; 8 stores all drained in order.
- Assert rst while 3 entries pending and dm_req_o=1 → outputs go to reset values immediately; after release, sb_empty_o=1; no stale write appears.
